// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the five-stage RISC-V core.
// Define FETCH_PERF_EN to add the perf_bubbles / perf_redirects counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] inst_id,
    output logic        valid_id,
    output logic        fetch_wait
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_bubbles,
    output logic [31:0] perf_redirects
`endif
);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_if_q, pc_if_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;

    logic        req;
    logic [31:0] req_addr;
    logic        deliver;
    logic [31:0] deliver_data;
    state_e      rst_state;

    // A request still in flight when reset hits must be drained, or its late
    // response would be mistaken for the answer to the first RESET_PC fetch.
    always_comb begin
        rst_state = ST_ISSUE;
        if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem_rvalid) begin
            rst_state = ST_DRAIN;
        end
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d      = state_q;
        pc_if_d      = pc_if_q;
        skid_d       = skid_q;
        req          = 1'b0;
        req_addr     = pc_if_q;
        deliver      = 1'b0;
        deliver_data = imem_rdata;

        case (state_q)
            ST_ISSUE: begin
                if (br_taken) begin
                    pc_if_d = br_target;
                end else begin
                    req     = 1'b1;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (br_taken) begin
                    pc_if_d = br_target;
                    state_d = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                end else if (imem_rvalid) begin
                    if (stall_if) begin
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end else begin
                        deliver  = 1'b1;
                        req      = 1'b1;
                        req_addr = pc_if_q + 32'd4;
                        pc_if_d  = pc_if_q + 32'd4;
                    end
                end
            end

            ST_DRAIN: begin
                if (br_taken) begin
                    pc_if_d = br_target;
                end
                if (imem_rvalid) begin
                    state_d = ST_ISSUE;
                end
            end

            ST_HOLD: begin
                if (br_taken) begin
                    pc_if_d = br_target;
                    state_d = ST_ISSUE;
                end else if (!stall_if) begin
                    deliver      = 1'b1;
                    deliver_data = skid_q;
                    pc_if_d      = pc_if_q + 32'd4;
                    state_d      = ST_ISSUE;
                end
            end

            default: begin
                state_d = ST_ISSUE;
            end
        endcase
    end

    // The delivered instruction's address is always pc_if_q: it only advances
    // in the same cycle the instruction leaves for IF/ID.
    always_comb begin
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        if (flush_id) begin
            valid_id_d = 1'b0;
            inst_id_d  = NOP_INSTR;
        end else if (!stall_id) begin
            if (deliver) begin
                valid_id_d = 1'b1;
                inst_id_d  = deliver_data;
                pc_id_d    = pc_if_q;
            end else begin
                valid_id_d = 1'b0;
                inst_id_d  = NOP_INSTR;
            end
        end
    end

    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= rst_state;
            pc_if_q    <= RESET_PC;
            skid_q     <= NOP_INSTR;
            pc_id_q    <= RESET_PC;
            inst_id_q  <= NOP_INSTR;
            valid_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_if_q    <= pc_if_d;
            skid_q     <= skid_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    assign imem_req   = req && !rst;
    assign imem_addr  = req_addr;
    assign pc_id      = pc_id_q;
    assign inst_id    = inst_id_q;
    assign valid_id   = valid_id_q;
    assign fetch_wait = !rst && !flush_id && !stall_id && !deliver;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_bubbles_q;
    logic [31:0] perf_redirects_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubbles_q   <= 32'd0;
            perf_redirects_q <= 32'd0;
        end else begin
            if (fetch_wait && (perf_bubbles_q != 32'hFFFF_FFFF)) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
            if (br_taken && (perf_redirects_q != 32'hFFFF_FFFF)) begin
                perf_redirects_q <= perf_redirects_q + 32'd1;
            end
        end
    end

    assign perf_bubbles   = perf_bubbles_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule
